sb_ram40_4k: RTL and testbench

- Behavioural model of a 4 Kbit synchronous block RAM with separate read and write ports, organised physically as 256 x 16.
- Single clock domain; write and read ports share `clk`.
- Used as the storage primitive under small explicit-memory wrappers (register files, scratch buffers).
- Configurable logical aspect ratio per port.

---
 rtl/sb_ram40_4k.sv | 141 ++++++++++++++
 tb/tb_sb_ram40_4k.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sb_ram40_4k.sv
// sb_ram40_4k: 4 Kbit synchronous block RAM with separate read and write ports.
// The physical array is 256 rows x 16 bits. Each port has its own logical
// aspect ratio (mode m -> width 16>>m), and both ports map onto that same array.
//
// Optional feature macro: SB_RAM40_INIT_EN
//   defined   : the array is preloaded from INIT_0..INIT_F
//   undefined : the INIT_* parameters are ignored and the array powers up zero
//
// Ports:
//   clk    - single clock for both ports, rising edge
//   rst    - async active-high reset; clears the read register only
//   rdata  - registered read data, zero-extended lane
//   raddr  - read address (bits above 7+READ_MODE ignored)
//   waddr  - write address (bits above 7+WRITE_MODE ignored)
//   mask   - per-bit write mask, active low, honoured only in write mode 0
//   wdata  - write data (low 16>>WRITE_MODE bits used in modes 1-3)
//   rclke  - read clock enable
//   re     - read enable
//   wclke  - write clock enable
//   we     - write enable
module sb_ram40_4k #(
   parameter int unsigned  READ_MODE  = 0,
   parameter int unsigned  WRITE_MODE = 0,
   parameter logic [255:0] INIT_0 = 256'h0,
   parameter logic [255:0] INIT_1 = 256'h0,
   parameter logic [255:0] INIT_2 = 256'h0,
   parameter logic [255:0] INIT_3 = 256'h0,
   parameter logic [255:0] INIT_4 = 256'h0,
   parameter logic [255:0] INIT_5 = 256'h0,
   parameter logic [255:0] INIT_6 = 256'h0,
   parameter logic [255:0] INIT_7 = 256'h0,
   parameter logic [255:0] INIT_8 = 256'h0,
   parameter logic [255:0] INIT_9 = 256'h0,
   parameter logic [255:0] INIT_A = 256'h0,
   parameter logic [255:0] INIT_B = 256'h0,
   parameter logic [255:0] INIT_C = 256'h0,
   parameter logic [255:0] INIT_D = 256'h0,
   parameter logic [255:0] INIT_E = 256'h0,
   parameter logic [255:0] INIT_F = 256'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] rdata,
   input  logic [10:0] raddr,
   input  logic [10:0] waddr,
   input  logic [15:0] mask,
   input  logic [15:0] wdata,
   input  logic        rclke,
   input  logic        re,
   input  logic        wclke,
   input  logic        we
);

   localparam int unsigned RW = 16 >> READ_MODE;
   localparam int unsigned WW = 16 >> WRITE_MODE;
   localparam logic [15:0] RLOW = 16'((32'd1 << RW) - 32'd1);
   localparam logic [15:0] WLOW = 16'((32'd1 << WW) - 32'd1);
   localparam logic [10:0] RLANE_M = 11'((32'd1 << READ_MODE) - 32'd1);
   localparam logic [10:0] WLANE_M = 11'((32'd1 << WRITE_MODE) - 32'd1);

   typedef logic [15:0] mem_t [0:255];

   // Row r of INIT_n lands in physical row 16n+r.
   function automatic mem_t init_image();
      mem_t         m;
      logic [255:0] seg;
      for (int unsigned n = 0; n < 16; n++) begin
         case (n)
            0:       seg = INIT_0;
            1:       seg = INIT_1;
            2:       seg = INIT_2;
            3:       seg = INIT_3;
            4:       seg = INIT_4;
            5:       seg = INIT_5;
            6:       seg = INIT_6;
            7:       seg = INIT_7;
            8:       seg = INIT_8;
            9:       seg = INIT_9;
            10:      seg = INIT_A;
            11:      seg = INIT_B;
            12:      seg = INIT_C;
            13:      seg = INIT_D;
            14:      seg = INIT_E;
            default: seg = INIT_F;
         endcase
         for (int unsigned r = 0; r < 16; r++) begin
            m[8'(16 * n + r)] = seg[8'(16 * r) +: 16];
         end
      end
      return m;
   endfunction

`ifdef SB_RAM40_INIT_EN
   mem_t mem = init_image();
`else
   mem_t mem = '{default: '0};
`endif

   logic [7:0]  wrow;
   logic [7:0]  rrow;
   logic [3:0]  woff;
   logic [3:0]  roff;
   logic [15:0] wben;
   logic [15:0] wval;
   logic [15:0] rword;

   // Each port computes its row, its lane bit offset, and (for writes) a
   // bit-enable vector, so a single row-wide read-modify-write covers every mode.
   always_comb begin
      wrow  = 8'(waddr >> WRITE_MODE);
      rrow  = 8'(raddr >> READ_MODE);
      woff  = 4'(WW * 32'(waddr & WLANE_M));
      roff  = 4'(RW * 32'(raddr & RLANE_M));
      wben  = '0;
      wval  = '0;
      if (WRITE_MODE == 0) begin
         wben = ~mask;
         wval = wdata;
      end else begin
         wben = WLOW << woff;
         wval = (wdata & WLOW) << woff;
      end
      rword = (mem[rrow] >> roff) & RLOW;
   end

   // Non-blocking update means a same-edge read sees the pre-write row.
   always_ff @(posedge clk) begin
      if (wclke && we) begin
         mem[wrow] <= (mem[wrow] & ~wben) | (wval & wben);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (rclke && re) begin
         rdata <= rword;
      end
   end

endmodule

// File: tb/tb_sb_ram40_4k.sv
module tb_sb_ram40_4k;

   typedef struct {
      logic        wclke;
      logic        we;
      logic [10:0] waddr;
      logic [15:0] wdata;
      logic [15:0] mask;
      logic        rclke;
      logic        re;
      logic [10:0] raddr;
      logic [15:0] exp;
   } vec_t;

`ifdef SB_RAM40_INIT_EN
   localparam logic [15:0] INIT_EXP = 16'hBEEF;
`else
   localparam logic [15:0] INIT_EXP = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] rdata0, rdata1;
   logic [10:0] raddr0, waddr0, raddr1, waddr1;
   logic [15:0] mask0, wdata0, mask1, wdata1;
   logic        rclke0, re0, wclke0, we0;
   logic        rclke1, re1, wclke1, we1;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   sb_ram40_4k #(
      .READ_MODE (0),
      .WRITE_MODE(0),
      .INIT_0    (256'hBEEF)
   ) dut0 (
      .clk  (clk),
      .rst  (rst),
      .rdata(rdata0),
      .raddr(raddr0),
      .waddr(waddr0),
      .mask (mask0),
      .wdata(wdata0),
      .rclke(rclke0),
      .re   (re0),
      .wclke(wclke0),
      .we   (we0)
   );

   sb_ram40_4k #(
      .READ_MODE (1),
      .WRITE_MODE(1)
   ) dut1 (
      .clk  (clk),
      .rst  (rst),
      .rdata(rdata1),
      .raddr(raddr1),
      .waddr(waddr1),
      .mask (mask1),
      .wdata(wdata1),
      .rclke(rclke1),
      .re   (re1),
      .wclke(wclke1),
      .we   (we1)
   );

   function automatic vec_t mk(logic wc, logic w, logic [10:0] wa, logic [15:0] wd,
                               logic [15:0] m, logic rc, logic r, logic [10:0] ra,
                               logic [15:0] e);
      vec_t v;
      v.wclke = wc; v.we = w; v.waddr = wa; v.wdata = wd; v.mask = m;
      v.rclke = rc; v.re = r; v.raddr = ra; v.exp = e;
      return v;
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: rdata=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic idle();
      wclke0 = 0; we0 = 0; rclke0 = 0; re0 = 0;
      waddr0 = '0; raddr0 = '0; wdata0 = '0; mask0 = '1;
      wclke1 = 0; we1 = 0; rclke1 = 0; re1 = 0;
      waddr1 = '0; raddr1 = '0; wdata1 = '0; mask1 = '1;
   endtask

   // Drives one vector on the selected DUT for one edge; the expected rdata
   // after that edge goes through the scoreboard queue.
   task automatic apply(input bit d, input vec_t v, input string nm);
      logic [15:0] got;
      idle();
      if (!d) begin
         wclke0 = v.wclke; we0 = v.we; waddr0 = v.waddr; wdata0 = v.wdata;
         mask0 = v.mask; rclke0 = v.rclke; re0 = v.re; raddr0 = v.raddr;
      end else begin
         wclke1 = v.wclke; we1 = v.we; waddr1 = v.waddr; wdata1 = v.wdata;
         mask1 = v.mask; rclke1 = v.rclke; re1 = v.re; raddr1 = v.raddr;
      end
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      got = d ? rdata1 : rdata0;
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         check(nm, got, exp_q.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t t0[18];
      vec_t t1[8];

      //            wc we waddr   wdata     mask      rc re raddr   exp
      t0[0]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd0,   INIT_EXP);
      t0[1]  = mk(1, 1, 11'd5,   16'hABCD, 16'h0000, 0, 0, 11'd0,   INIT_EXP);
      t0[2]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd5,   16'hABCD);
      t0[3]  = mk(1, 1, 11'd5,   16'h1234, 16'hFF00, 0, 0, 11'd0,   16'hABCD);
      t0[4]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd5,   16'hAB34);
      t0[5]  = mk(0, 1, 11'd7,   16'hFFFF, 16'h0000, 0, 0, 11'd0,   16'hAB34);
      t0[6]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd7,   16'h0000);
      t0[7]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 0, 11'd5,   16'h0000);
      t0[8]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 0, 1, 11'd5,   16'h0000);
      t0[9]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 0, 11'd5,   16'h0000);
      t0[10] = mk(1, 1, 11'd9,   16'h0001, 16'h0000, 0, 0, 11'd0,   16'h0000);
      t0[11] = mk(1, 1, 11'd9,   16'h0002, 16'h0000, 1, 1, 11'd9,   16'h0001);
      t0[12] = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd9,   16'h0002);
      t0[13] = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'h105, 16'hAB34);
      t0[14] = mk(1, 1, 11'd10,  16'hFFFF, 16'hFFFF, 1, 1, 11'd10,  16'h0000);
      t0[15] = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd10,  16'h0000);
      t0[16] = mk(1, 1, 11'd255, 16'h5555, 16'h0000, 0, 0, 11'd0,   16'h0000);
      t0[17] = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd255, 16'h5555);

      t1[0]  = mk(1, 1, 11'd0,   16'h005A, 16'hFFFF, 0, 0, 11'd0,   16'h0000);
      t1[1]  = mk(1, 1, 11'd1,   16'h00C3, 16'hFFFF, 0, 0, 11'd0,   16'h0000);
      t1[2]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd0,   16'h005A);
      t1[3]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd1,   16'h00C3);
      t1[4]  = mk(1, 1, 11'd3,   16'hFF77, 16'hFFFF, 1, 1, 11'd3,   16'h0000);
      t1[5]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd3,   16'h0077);
      t1[6]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'd2,   16'h0000);
      t1[7]  = mk(0, 0, 11'd0,   16'h0000, 16'hFFFF, 1, 1, 11'h201, 16'h00C3);

      idle();
      rst = 1'b1;
      #2;
      check("reset0", rdata0, 16'h0000);
      check("reset1", rdata1, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 18; i++) apply(1'b0, t0[i], $sformatf("m0_vec%0d", i));
      for (int i = 0; i < 8; i++)  apply(1'b1, t1[i], $sformatf("m1_vec%0d", i));

      // Asynchronous reset mid-cycle, writes continuing under reset, memory kept.
      apply(1'b0, mk(1, 1, 11'd5, 16'hABCD, 16'h0000, 0, 0, 11'd0, 16'h5555), "rst_pre_wr");
      apply(1'b0, mk(0, 0, 11'd0, 16'h0000, 16'hFFFF, 1, 1, 11'd5, 16'hABCD), "rst_pre_rd");
      #3;
      rst = 1'b1;
      #1;
      check("rst_async", rdata0, 16'h0000);
      apply(1'b0, mk(1, 1, 11'd11, 16'h7777, 16'h0000, 1, 1, 11'd5, 16'h0000), "rst_blocks_rd");
      #3;
      rst = 1'b0;
      apply(1'b0, mk(0, 0, 11'd0, 16'h0000, 16'hFFFF, 1, 1, 11'd11, 16'h7777), "rst_wr_kept");
      apply(1'b0, mk(0, 0, 11'd0, 16'h0000, 16'hFFFF, 1, 1, 11'd5,  16'hABCD), "rst_mem_kept");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
